// File: rtl/tff_pkg.sv
// Shared direction constants and load-value clamping for the T-flip-flop counter.
// Pure definitions: no state, no latency, no flow control.
package tff_pkg;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // Out-of-range load values saturate to the top of the count sequence.
    function automatic int unsigned clamp_load(input int unsigned val, input int unsigned mod_n);
        return (val < mod_n) ? val : mod_n - 1;
    endfunction

endpackage

// File: rtl/tff_cell.sv
// Single falling-edge T flip-flop with asynchronous active-high clear.
// Latency: q toggles at the falling edge where t=1; no backpressure (no flow control).
module tff_cell (
    input  logic clk,
    input  logic rst,
    input  logic t,
    output logic q
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = q_q ^ t;
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/tff_counter.sv
// Modulo-N up/down counter with load, built from a bank of falling-edge T flip-flops.
// Latency: q and wrap update at the falling edge that samples the controls; tc is combinational; no backpressure.
module tff_counter
    import tff_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MOD_N = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
        $error("tff_counter: WIDTH=%0d outside 1..16", WIDTH);
    end
    if (MOD_N < 2 || MOD_N > (1 << WIDTH)) begin : g_bad_mod
        $error("tff_counter: MOD_N=%0d outside 2..2**WIDTH", MOD_N);
    end

    // With a full binary range the plain carry/borrow toggles already wrap correctly.
    localparam bit               FULL_RANGE = (MOD_N == (1 << WIDTH));
    localparam logic [WIDTH-1:0] MAX_VAL    = WIDTH'(MOD_N - 1);

    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] t_up;
    logic [WIDTH-1:0] t_dn;
    logic [WIDTH-1:0] load_clamped;
    logic             run_up;
    logic             run_dn;
    logic             at_max;
    logic             at_zero;
    logic             wrap_d;
    logic             wrap_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        tff_cell u_cell (
            .clk (clk),
            .rst (rst),
            .t   (t[i]),
            .q   (q[i])
        );
    end

    assign load_clamped = WIDTH'(clamp_load(32'(load_val), 32'(MOD_N)));
    assign at_max       = (q == MAX_VAL);
    assign at_zero      = (q == '0);

    always_comb begin
        t_up   = '0;
        t_dn   = '0;
        run_up = 1'b1;
        run_dn = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            t_up[i] = run_up;
            t_dn[i] = run_dn;
            run_up  = run_up & q[i];
            run_dn  = run_dn & ~q[i];
        end
    end

    // Every next-state path is expressed as a toggle mask applied to the cells.
    always_comb begin
        t      = '0;
        wrap_d = 1'b0;
        if (load) begin
            t = q ^ load_clamped;
        end else if (en) begin
            if (up_dn == DIR_UP) begin
                if (at_max) begin
                    wrap_d = 1'b1;
                    t      = FULL_RANGE ? t_up : q;
                end else begin
                    t = t_up;
                end
            end else begin
                if (at_zero) begin
                    wrap_d = 1'b1;
                    t      = FULL_RANGE ? t_dn : (q ^ MAX_VAL);
                end else begin
                    t = t_dn;
                end
            end
        end
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign wrap = wrap_q;
    assign tc   = en & ~load & (((up_dn == DIR_UP) & at_max) | ((up_dn == DIR_DN) & at_zero));

endmodule

// File: doc/tff_counter.md
Name: tff_counter

Overview:
- Parametrised counter built from a bank of falling-edge T flip-flops.
- Each bit's toggle enable is derived per cycle from enable, direction, current count and the modulus.
- Adds load, up/down, modulo-N wrap and terminal-count/wrap flags.
- Used as a general divider and event counter wherever the single-bit toggle cell is too limited.

Parameters:
- WIDTH, 4, counter width in bits (1..16).
- MOD_N, 16, count modulus. Sequence is 0..MOD_N-1. Legal range is 2..2**WIDTH.

Ports:
- clk  input  1  clock; all state changes on falling edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  count enable.
- up_dn  input  1  1 = count up, 0 = count down.
- load  input  1  synchronous parallel load.
- load_val  input  WIDTH  value to load.
- q  output  WIDTH  current count.
- tc  output  1  terminal count (combinational).
- wrap  output  1  registered one-cycle pulse after a wrap.

Behaviour:
- Clocking and reset:
  - Clock is negedge clk; no logic uses posedge.
  - Reset is asynchronous, active-high: while rst=1, q=0 and wrap=0 immediately, independent of clk.
  - Reset asserted mid-count aborts the count. First falling edge after rst deasserts evaluates normally from q=0.
- Priority each falling edge: rst > load > en > hold.
- Load:
  - load=1: q <= load_val if load_val < MOD_N, else q <= MOD_N-1 (clamp).
  - wrap <= 0 on a load edge.
  - load ignores en and up_dn.
- Count up (en=1, up_dn=1):
  - If q == MOD_N-1: next q = 0 and wrap <= 1.
  - Else q <= q+1 and wrap <= 0.
- Count down (en=1, up_dn=0):
  - If q == 0: next q = MOD_N-1 and wrap <= 1.
  - Else q <= q-1 and wrap <= 0.
- Hold: en=0, load=0 → q unchanged, wrap <= 0.
- Toggle-vector implementation (required):
  - Each bit i is a T flip-flop. The next count is produced only through a toggle vector t, where q_next = q XOR t.
  - Normal up: t[i] = en & AND(q[i-1:0]).
  - Normal down: t[i] = en & AND(~q[i-1:0]).
  - Wrap cycles: t = q XOR wrap_target.
  - Load: t = q XOR clamped load_val.
  - When MOD_N = 2**WIDTH, the wrap path must reduce to natural binary rollover.
- tc = en & ~load & ((up_dn & q==MOD_N-1) | (~up_dn & q==0)). Combinational, valid before the edge it describes.
- Direction change takes effect at the next edge: no extra cycle, no skipped value.
- Latency:
  - q updates at the same falling edge that samples the controls.
  - wrap asserts for exactly one clk period, from the wrapping edge to the next edge.
- Simultaneous load=1 and en=1 with tc=1: load wins, no wrap pulse.
- Illegal parameters (MOD_N < 2 or MOD_N > 2**WIDTH) must stop elaboration with an error.

Decomposition:
- Shared package tff_pkg:
  - Direction constants DIR_UP=1'b1 and DIR_DN=1'b0.
  - A function computing clamp(load_val, MOD_N).
- Sub-module tff_cell:
  - One falling-edge T flip-flop: ports clk, rst, t, q.
  - Async active-high reset to 0.
  - Instantiated WIDTH times via generate.
- Top level holds the toggle-vector logic, tc and the wrap register.

Test Plan (WIDTH=4, MOD_N=10, clk period 80 ns):
- Reset, then en=1, up_dn=1 for 12 falling edges → q = 1,2,…,9,0,1,2. tc=1 only while q=9. wrap high exactly one period after the 9→0 edge.
- From q=0, en=1, up_dn=0 → q = 9,8,7. wrap pulses once after the 0→9 edge. tc=1 while q=0.
- load=1, load_val=4'd13 with en=1 → q=9 after the edge, no wrap. Then load_val=4'd5 → q=5.
- Count up to q=6, drop en for 3 edges → q holds 6, wrap=0. Raise en → q=7 on the next edge.
- Assert rst 10 ns after a falling edge with q=7 → q=0 and wrap=0 before the next edge. Deassert → counting resumes 1,2 on the following edges.
- Parameter sweep WIDTH=4, MOD_N=16: up from 15 → 0 with wrap=1. Down from 0 → 15. Confirms pure-binary rollover path.
